// File: rtl/game_pkg.sv
// Shared snake-game definitions: game status codes, grid geometry, pixel classes
// and the apple spawner state encoding.
package game_pkg;

    localparam logic [1:0] PLAY = 2'b10;

    localparam logic [5:0] X_MIN = 6'd1;
    localparam logic [5:0] X_MAX = 6'd38;
    localparam logic [5:0] Y_MIN = 6'd1;
    localparam logic [5:0] Y_MAX = 6'd28;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;

    typedef enum logic [1:0] {
        PIX_NONE = 2'd0,
        PIX_HEAD = 2'd1,
        PIX_BODY = 2'd2,
        PIX_WALL = 2'd3
    } pix_class_t;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_EATEN  = 2'd1,
        ST_PLACE  = 2'd2
    } spawn_state_t;

    // True when the cell lies inside the wall ring.
    function automatic logic in_playable(input logic [5:0] cx, input logic [5:0] cy);
        return (cx >= X_MIN) && (cx <= X_MAX) && (cy >= Y_MIN) && (cy <= Y_MAX);
    endfunction

endpackage

// File: rtl/apple_spawner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_out
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (!reset)
            r_lfsr <= SEED;
        else
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign lfsr_out = r_lfsr;

endmodule

// File: rtl/apple_spawner.sv
// Apple food source: detects the head eating the apple, issues the grow pulse,
// keeps the score and re-places the apple from an LFSR.
module apple_spawner
    import game_pkg::*;
#(
    parameter int unsigned ADD_PULSE = 4,
    parameter int unsigned MAX_LEN   = 16,
    parameter logic [5:0]  APPLE_X0  = 6'd24,
    parameter logic [5:0]  APPLE_Y0  = 6'd10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] game_status,
    input  logic [5:0] head_x,
    input  logic [5:0] head_y,
    input  logic [6:0] cube_num,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic       add_cube,
    output logic [5:0] apple_x,
    output logic [5:0] apple_y,
    output logic       apple_valid,
    output logic       apple_pixel,
    output logic [7:0] score
);

    localparam int CNT_W = $clog2(ADD_PULSE + 1);
    localparam logic [9:0] PIX_W = 10'(GRID_W << CELL_SHIFT);
    localparam logic [9:0] PIX_H = 10'(GRID_H << CELL_SHIFT);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    spawn_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_add;
    logic [5:0]       r_ax;
    logic [5:0]       r_ay;
    logic             r_valid;
    logic [7:0]       r_score;

    logic [15:0] w_lfsr;
    logic [5:0]  w_cx;
    logic [5:0]  w_cy;
    logic        w_eat;
    logic        w_accept;
    logic        w_unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .lfsr_out (w_lfsr)
    );

    assign w_cx          = w_lfsr[5:0];
    assign w_cy          = {1'b0, w_lfsr[12:8]};
    assign w_unused_lfsr = ^{w_lfsr[15:13], w_lfsr[7:6]};

    assign w_eat    = (game_status == PLAY) && (head_x == r_ax) && (head_y == r_ay);
    assign w_accept = in_playable(w_cx, w_cy) && !((w_cx == head_x) && (w_cy == head_y));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_ACTIVE;
            r_cnt   <= '0;
            r_add   <= 1'b0;
            r_ax    <= APPLE_X0;
            r_ay    <= APPLE_Y0;
            r_valid <= 1'b1;
            r_score <= 8'd0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (w_eat) begin
                        r_state <= ST_EATEN;
                        r_valid <= 1'b0;
                        r_score <= sat_inc8(r_score);
                        r_cnt   <= CNT_W'(1);
                        r_add   <= (cube_num < 7'(MAX_LEN));
                    end
                end
                // The pulse ends on the edge where the count reaches ADD_PULSE,
                // which keeps add_cube high for exactly ADD_PULSE cycles.
                ST_EATEN: begin
                    if (r_cnt == CNT_W'(ADD_PULSE)) begin
                        r_add   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_PLACE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PLACE: begin
                    if (w_accept) begin
                        r_ax    <= w_cx;
                        r_ay    <= w_cy;
                        r_valid <= 1'b1;
                        r_state <= ST_ACTIVE;
                    end
                end
                default: r_state <= ST_ACTIVE;
            endcase
        end
    end

    assign add_cube    = r_add;
    assign apple_x     = r_ax;
    assign apple_y     = r_ay;
    assign apple_valid = r_valid;
    assign score       = r_score;

    assign apple_pixel = r_valid && (x_pos < PIX_W) && (y_pos < PIX_H) &&
                         (x_pos[9:CELL_SHIFT] == r_ax) && (y_pos[9:CELL_SHIFT] == r_ay);

endmodule

// File: tb/tb_apple_spawner.sv
// Self-checking bench for apple_spawner: constant vector table for reset and the
// first eat, then a reference model driving a scoreboard for longer sequences.
module tb_apple_spawner;

    localparam int M_PULSE = 4;
    localparam int M_MAXLEN = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] game_status;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [6:0] cube_num;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       add_cube;
    logic [5:0] apple_x;
    logic [5:0] apple_y;
    logic       apple_valid;
    logic       apple_pixel;
    logic [7:0] score;

    always #5 clk = ~clk;

    apple_spawner dut (
        .clk         (clk),
        .reset       (reset),
        .game_status (game_status),
        .head_x      (head_x),
        .head_y      (head_y),
        .cube_num    (cube_num),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .add_cube    (add_cube),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .apple_pixel (apple_pixel),
        .score       (score)
    );

    typedef struct packed {
        logic       add;
        logic [5:0] ax;
        logic [5:0] ay;
        logic       v;
        logic       pix;
        logic [7:0] sc;
    } t_exp;

    typedef struct {
        logic       rst_n;
        logic [1:0] gs;
        logic [5:0] hx;
        logic [5:0] hy;
        logic [6:0] cube;
        logic [9:0] xp;
        logic [9:0] yp;
        t_exp       e;
    } t_vec;

    t_exp q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int          m_st;
    int          m_cnt;
    logic [15:0] m_lfsr;
    logic        m_add;
    logic        m_v;
    int          m_ax;
    int          m_ay;
    int          m_sc;

    function automatic t_exp model_out();
        t_exp e;
        e.add = m_add;
        e.ax  = 6'(m_ax);
        e.ay  = 6'(m_ay);
        e.v   = m_v;
        e.sc  = 8'(m_sc);
        e.pix = m_v && (int'(x_pos) < 640) && (int'(y_pos) < 480) &&
                (int'(x_pos) / 16 == m_ax) && (int'(y_pos) / 16 == m_ay);
        return e;
    endfunction

    task automatic model_step();
        logic fb;
        int   cx;
        int   cy;
        if (!reset) begin
            m_st = 0; m_cnt = 0; m_lfsr = 16'hACE1; m_add = 0;
            m_v = 1; m_ax = 24; m_ay = 10; m_sc = 0;
        end else begin
            cx = int'(m_lfsr) % 64;
            cy = (int'(m_lfsr) / 256) % 32;
            fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
            case (m_st)
                0: if (game_status == 2'b10 && int'(head_x) == m_ax && int'(head_y) == m_ay) begin
                    m_st = 1; m_v = 0; m_cnt = 1;
                    m_sc = (m_sc < 255) ? m_sc + 1 : 255;
                    m_add = (int'(cube_num) < M_MAXLEN);
                end
                1: if (m_cnt == M_PULSE) begin
                    m_add = 0; m_st = 2;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                default: if (cx >= 1 && cx <= 38 && cy >= 1 && cy <= 28 &&
                             !(cx == int'(head_x) && cy == int'(head_y))) begin
                    m_ax = cx; m_ay = cy; m_v = 1; m_st = 0;
                end
            endcase
            m_lfsr = {m_lfsr[14:0], fb};
        end
    endtask

    function automatic t_exp dut_out();
        t_exp e;
        e.add = add_cube; e.ax = apple_x; e.ay = apple_y;
        e.v = apple_valid; e.pix = apple_pixel; e.sc = score;
        return e;
    endfunction

    task automatic report(input string name, input t_exp act, input t_exp exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got add=%0d ax=%0d ay=%0d v=%0d pix=%0d sc=%0d, want add=%0d ax=%0d ay=%0d v=%0d pix=%0d sc=%0d",
                     name, act.add, act.ax, act.ay, act.v, act.pix, act.sc,
                     exp.add, exp.ax, exp.ay, exp.v, exp.pix, exp.sc);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc_with(input t_exp e_tab, input bit use_tab, input string name);
        t_exp e;
        @(posedge clk);
        model_step();
        q.push_back(use_tab ? e_tab : model_out());
        #1;
        e = q.pop_front();
        report(name, dut_out(), e);
    endtask

    task automatic cyc();
        cyc_with('0, 1'b0, "model");
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!apple_valid && k < 300) begin
            cyc();
            k++;
        end
        check({name, "_timeout"}, int'(apple_valid), 1);
        check({name, "_xrange"}, int'(apple_x >= 6'd1 && apple_x <= 6'd38), 1);
        check({name, "_yrange"}, int'(apple_y >= 6'd1 && apple_y <= 6'd28), 1);
    endtask

    task automatic do_eat(input logic [6:0] cube);
        wait_valid("eat_place");
        head_x = apple_x; head_y = apple_y;
        x_pos = {apple_x, 4'd7}; y_pos = {apple_y, 4'd9};
        game_status = 2'b10; cube_num = cube;
        cyc();
    endtask

    function automatic t_vec mkv(input logic r, input logic [1:0] gs, input int hx, input int hy,
                                 input int cube, input int xp, input int yp, input logic add,
                                 input int ax, input int ay, input logic v, input logic pix, input int sc);
        t_vec t;
        t.rst_n = r; t.gs = gs; t.hx = 6'(hx); t.hy = 6'(hy); t.cube = 7'(cube);
        t.xp = 10'(xp); t.yp = 10'(yp);
        t.e.add = add; t.e.ax = 6'(ax); t.e.ay = 6'(ay); t.e.v = v; t.e.pix = pix; t.e.sc = 8'(sc);
        return t;
    endfunction

    t_vec tab[10];

    initial begin
        int sc_before;
        int add_seen;

        tab[0] = mkv(0, 2'b00, 10, 5, 3, 384, 160, 0, 24, 10, 1, 1, 0);
        tab[1] = mkv(0, 2'b00, 10, 5, 3, 400, 160, 0, 24, 10, 1, 0, 0);
        tab[2] = mkv(1, 2'b10, 10, 5, 3, 384, 160, 0, 24, 10, 1, 1, 0);
        tab[3] = mkv(1, 2'b01, 24, 10, 3, 384, 160, 0, 24, 10, 1, 1, 0);
        tab[4] = mkv(1, 2'b01, 24, 10, 3, 384, 160, 0, 24, 10, 1, 1, 0);
        tab[5] = mkv(1, 2'b10, 24, 10, 3, 384, 160, 1, 24, 10, 0, 0, 1);
        tab[6] = mkv(1, 2'b10, 24, 10, 3, 384, 160, 1, 24, 10, 0, 0, 1);
        tab[7] = mkv(1, 2'b10, 24, 10, 3, 384, 160, 1, 24, 10, 0, 0, 1);
        tab[8] = mkv(1, 2'b10, 24, 10, 3, 384, 160, 1, 24, 10, 0, 0, 1);
        tab[9] = mkv(1, 2'b10, 24, 10, 3, 384, 160, 0, 24, 10, 0, 0, 1);

        reset = 0; game_status = 2'b00; head_x = 6'd10; head_y = 6'd5;
        cube_num = 7'd3; x_pos = 10'd384; y_pos = 10'd160;

        for (int i = 0; i < 10; i++) begin
            reset = tab[i].rst_n; game_status = tab[i].gs;
            head_x = tab[i].hx; head_y = tab[i].hy; cube_num = tab[i].cube;
            x_pos = tab[i].xp; y_pos = tab[i].yp;
            cyc_with(tab[i].e, 1'b1, $sformatf("vec%0d", i));
        end

        // Head stays on the old apple cell during placement
        wait_valid("place1");
        check("place1_moved", int'(apple_x == 6'd24 && apple_y == 6'd10), 0);
        check("place1_score", int'(score), 1);

        // Length cap: no grow request, score still counts
        sc_before = int'(score);
        do_eat(7'd16);
        add_seen = int'(add_cube);
        repeat (8) begin
            cyc();
            add_seen += int'(add_cube);
        end
        check("cap_no_add", add_seen, 0);
        check("cap_score", int'(score), sc_before + 1);

        // Reset during the second cycle of a grow pulse
        do_eat(7'd3);
        check("midrst_pulse1", int'(add_cube), 1);
        cyc();
        check("midrst_pulse2", int'(add_cube), 1);
        reset = 0;
        cyc();
        check("midrst_add", int'(add_cube), 0);
        check("midrst_ax", int'(apple_x), 24);
        check("midrst_ay", int'(apple_y), 10);
        check("midrst_valid", int'(apple_valid), 1);
        check("midrst_score", int'(score), 0);
        reset = 1;

        // Score saturation
        for (int i = 0; i < 256; i++) begin
            do_eat(7'd3);
            if (i == 254) check("sat_reach", int'(score), 255);
        end
        check("sat_hold", int'(score), 255);
        repeat (6) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
